// File: rtl/ps2_device_xcvr.sv
// Device-side PS/2 transceiver (mouse/keyboard end of the link).
// Generates the PS/2 clock, sends device-to-host frames, receives and ACKs
// host-to-device command frames and backs off whenever the host inhibits.
// Lines are driven open-drain: an OE output of 1 pulls that line low.
module ps2_device_xcvr #(
    parameter int HALF_PERIOD = 2000,
    parameter int IDLE_MIN    = 2500,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TX_DONE,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_ERROR,
    output logic       BUSY,
    input  logic       PS2_CLK_IN,
    output logic       PS2_CLK_OE,
    input  logic       PS2_DATA_IN,
    output logic       PS2_DATA_OE
);

    localparam int HALF_W = $clog2(HALF_PERIOD + 1);
    localparam int IDLE_W = $clog2(IDLE_MIN + 1);
    localparam logic [HALF_W-1:0] HALF_RELOAD = HALF_W'(HALF_PERIOD - 1);
    localparam logic [HALF_W-1:0] HALF_ONE    = HALF_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT  = IDLE_W'(IDLE_MIN);
    localparam logic [IDLE_W-1:0] IDLE_ONE    = IDLE_W'(1);

    typedef enum logic [2:0] {ST_IDLE, ST_TX, ST_INHIBIT, ST_RX, ST_ACK} state_t;
    // HIGH/LOW are the two clock half-phases; TAIL is the released wait after a TX frame.
    typedef enum logic [1:0] {PH_HIGH, PH_LOW, PH_TAIL} phase_t;

    state_t              state_reg;
    phase_t              phase_reg;
    logic [HALF_W-1:0]   half_cnt_reg;
    logic [3:0]          bit_cnt_reg;
    logic [IDLE_W-1:0]   idle_cnt_reg;
    logic                pending_reg;
    logic [7:0]          tx_byte_reg;
    logic [8:0]          rx_shift_reg;
    logic [7:0]          rx_data_reg;
    logic                rx_valid_reg;
    logic                rx_error_reg;
    logic                tx_done_reg;
    logic                clk_oe_reg;
    logic                data_oe_reg;

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] dat_sync_reg;
    logic [SYNC_STAGES-1:0] clk_sync_next;
    logic [SYNC_STAGES-1:0] dat_sync_next;

    // Synchroniser chain: stage 0 takes the pin, each later stage the one before it.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign clk_sync_next[gi] = PS2_CLK_IN;
            assign dat_sync_next[gi] = PS2_DATA_IN;
        end else begin : g_rest
            assign clk_sync_next[gi] = clk_sync_reg[gi-1];
            assign dat_sync_next[gi] = dat_sync_reg[gi-1];
        end
    end

    // Shift the line levels through the synchroniser; idle lines read high.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            clk_sync_reg <= '1;
            dat_sync_reg <= '1;
        end else begin
            clk_sync_reg <= clk_sync_next;
            dat_sync_reg <= dat_sync_next;
        end
    end

    logic        sclk;
    logic        sdat;
    logic        half_done;
    logic        tx_fire;
    logic [10:0] tx_frame;

    assign sclk      = clk_sync_reg[SYNC_STAGES-1];
    assign sdat      = dat_sync_reg[SYNC_STAGES-1];
    assign half_done = (half_cnt_reg == '0);
    assign TX_READY  = (state_reg == ST_IDLE) && !pending_reg;
    assign tx_fire   = TX_VALID && TX_READY;
    // start 0, D0..D7, odd parity, stop 1 -- bit 0 goes out first
    assign tx_frame  = {1'b1, ~^tx_byte_reg, tx_byte_reg, 1'b0};

    assign BUSY        = (state_reg != ST_IDLE) || pending_reg;
    assign TX_DONE     = tx_done_reg;
    assign RX_DATA     = rx_data_reg;
    assign RX_VALID    = rx_valid_reg;
    assign RX_ERROR    = rx_error_reg;
    assign PS2_CLK_OE  = clk_oe_reg;
    assign PS2_DATA_OE = data_oe_reg;

    // Count consecutive cycles with both lines high, saturating at IDLE_MIN.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            idle_cnt_reg <= '0;
        end else if (sclk && sdat) begin
            if (idle_cnt_reg != IDLE_LIMIT) begin
                idle_cnt_reg <= idle_cnt_reg + IDLE_ONE;
            end
        end else begin
            idle_cnt_reg <= '0;
        end
    end

    // Link state machine with registered line drivers and status pulses.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg    <= ST_IDLE;
            phase_reg    <= PH_HIGH;
            half_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            pending_reg  <= 1'b0;
            tx_byte_reg  <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            rx_error_reg <= 1'b0;
            tx_done_reg  <= 1'b0;
            clk_oe_reg   <= 1'b0;
            data_oe_reg  <= 1'b0;
        end else begin
            tx_done_reg  <= 1'b0;
            rx_valid_reg <= 1'b0;
            rx_error_reg <= 1'b0;
            if (tx_fire) begin
                tx_byte_reg <= TX_DATA;
                pending_reg <= 1'b1;
            end
            if (!half_done) begin
                half_cnt_reg <= half_cnt_reg - HALF_ONE;
            end
            case (state_reg)
                ST_IDLE: begin
                    clk_oe_reg  <= 1'b0;
                    data_oe_reg <= 1'b0;
                    // A host holding the clock low wins over our own pending byte.
                    if (!sclk) begin
                        state_reg <= ST_INHIBIT;
                    end else if (pending_reg && (idle_cnt_reg == IDLE_LIMIT)) begin
                        state_reg    <= ST_TX;
                        phase_reg    <= PH_HIGH;
                        bit_cnt_reg  <= '0;
                        half_cnt_reg <= HALF_RELOAD;
                        data_oe_reg  <= ~tx_frame[0];
                    end
                end
                ST_TX: begin
                    if (half_done) begin
                        case (phase_reg)
                            PH_HIGH: begin
                                // Host pulled the clock low: drop the frame, resend it later.
                                if (!sclk) begin
                                    clk_oe_reg  <= 1'b0;
                                    data_oe_reg <= 1'b0;
                                    state_reg   <= ST_INHIBIT;
                                end else begin
                                    clk_oe_reg   <= 1'b1;
                                    phase_reg    <= PH_LOW;
                                    half_cnt_reg <= HALF_RELOAD;
                                end
                            end
                            PH_LOW: begin
                                clk_oe_reg   <= 1'b0;
                                half_cnt_reg <= HALF_RELOAD;
                                if (bit_cnt_reg == 4'd10) begin
                                    data_oe_reg <= 1'b0;
                                    phase_reg   <= PH_TAIL;
                                end else begin
                                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                                    data_oe_reg <= ~tx_frame[bit_cnt_reg + 4'd1];
                                    phase_reg   <= PH_HIGH;
                                end
                            end
                            default: begin
                                tx_done_reg <= 1'b1;
                                pending_reg <= 1'b0;
                                state_reg   <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_INHIBIT: begin
                    clk_oe_reg  <= 1'b0;
                    data_oe_reg <= 1'b0;
                    // Clock released: data held low means the host wants to send.
                    if (sclk) begin
                        if (!sdat) begin
                            state_reg    <= ST_RX;
                            clk_oe_reg   <= 1'b1;
                            phase_reg    <= PH_LOW;
                            bit_cnt_reg  <= '0;
                            half_cnt_reg <= HALF_RELOAD;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_RX: begin
                    if (half_done) begin
                        if (phase_reg == PH_LOW) begin
                            clk_oe_reg   <= 1'b0;
                            phase_reg    <= PH_HIGH;
                            half_cnt_reg <= HALF_RELOAD;
                        end else if (!sclk) begin
                            clk_oe_reg <= 1'b0;
                            state_reg  <= ST_INHIBIT;
                        end else if (bit_cnt_reg == 4'd9) begin
                            // Stop bit: a bad stop gets no ACK pulse at all.
                            if (!sdat) begin
                                rx_error_reg <= 1'b1;
                                state_reg    <= ST_IDLE;
                            end else begin
                                state_reg    <= ST_ACK;
                                data_oe_reg  <= 1'b1;
                                clk_oe_reg   <= 1'b1;
                                phase_reg    <= PH_LOW;
                                half_cnt_reg <= HALF_RELOAD;
                            end
                        end else begin
                            rx_shift_reg[bit_cnt_reg] <= sdat;
                            bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                            clk_oe_reg   <= 1'b1;
                            phase_reg    <= PH_LOW;
                            half_cnt_reg <= HALF_RELOAD;
                        end
                    end
                end
                ST_ACK: begin
                    if (half_done) begin
                        if (phase_reg == PH_LOW) begin
                            clk_oe_reg   <= 1'b0;
                            phase_reg    <= PH_HIGH;
                            half_cnt_reg <= HALF_RELOAD;
                        end else begin
                            data_oe_reg <= 1'b0;
                            state_reg   <= ST_IDLE;
                            if (^rx_shift_reg) begin
                                rx_data_reg  <= rx_shift_reg[7:0];
                                rx_valid_reg <= 1'b1;
                            end else begin
                                rx_error_reg <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device_xcvr.sv
// Directed bench for ps2_device_xcvr with a small open-drain host model.
module tb_ps2_device_xcvr;

    localparam int HP = 10;
    localparam int IM = 25;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_VALID = 1'b0;
    logic       host_clk_pull = 1'b0;
    logic       host_dat_pull = 1'b0;
    logic       TX_READY, TX_DONE, RX_VALID, RX_ERROR, BUSY;
    logic       PS2_CLK_OE, PS2_DATA_OE;
    logic [7:0] RX_DATA;
    logic       ps2_clk_line, ps2_dat_line;

    int vec_count = 0;
    int err_count = 0;

    assign ps2_clk_line = ~(PS2_CLK_OE | host_clk_pull);
    assign ps2_dat_line = ~(PS2_DATA_OE | host_dat_pull);

    always #5 CLK = ~CLK;

    ps2_device_xcvr #(.HALF_PERIOD(HP), .IDLE_MIN(IM), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESETN(RESETN), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .TX_DONE(TX_DONE), .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID), .RX_ERROR(RX_ERROR), .BUSY(BUSY),
        .PS2_CLK_IN(ps2_clk_line), .PS2_CLK_OE(PS2_CLK_OE),
        .PS2_DATA_IN(ps2_dat_line), .PS2_DATA_OE(PS2_DATA_OE)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            if (TX_READY) begin
                TX_DATA = b;
                TX_VALID = 1'b1;
                tick();
                TX_VALID = 1'b0;
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_clk_oe(input logic lvl, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            if (PS2_CLK_OE === lvl) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    // Records the line data at each falling edge of the line clock until TX_DONE.
    task automatic tx_capture(input int budget, output logic [10:0] bits, output int nedge,
                              output int lat, output int t0, output bit done);
        bit   started;
        logic prev;
        bits = '0; nedge = 0; lat = -1; t0 = -1; done = 0; started = 0;
        prev = ps2_clk_line;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (!started && PS2_DATA_OE) begin
                started = 1;
                t0 = c;
            end
            if (prev && !ps2_clk_line) begin
                if (nedge < 11) bits[nedge] = ps2_dat_line;
                nedge++;
            end
            prev = ps2_clk_line;
            if (TX_DONE) begin
                done = 1;
                lat = c - t0;
                break;
            end
        end
    endtask

    // Host-to-device frame: request-to-send, 10 bits clocked by the device, then watch for ACK.
    task automatic host_send(input logic [7:0] b, input logic par, input logic stop, input int hold,
                             output bit ok, output int rises, output logic ack_data,
                             output logic ack_hold, output int n_valid, output int n_error);
        logic [9:0] fr;
        bit         w;
        bit         seen_fall;
        logic       prev;
        fr = {stop, par, b};
        ok = 1; rises = 0; ack_data = 0; ack_hold = 0; n_valid = 0; n_error = 0;
        host_clk_pull = 1'b1;
        host_dat_pull = 1'b1;
        repeat (hold) tick();
        host_clk_pull = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_clk_oe(1'b1, 60, w);
            ok = ok & w;
            host_dat_pull = ~fr[k];
            wait_clk_oe(1'b0, 60, w);
            ok = ok & w;
        end
        prev = PS2_CLK_OE;
        seen_fall = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (PS2_CLK_OE && !prev) begin
                rises++;
                if (rises == 1) ack_data = PS2_DATA_OE;
            end
            if (!PS2_CLK_OE && prev && rises == 1 && !seen_fall) begin
                seen_fall = 1;
                ack_hold = PS2_DATA_OE;
            end
            prev = PS2_CLK_OE;
            if (RX_VALID) n_valid++;
            if (RX_ERROR) n_error++;
            if (n_valid + n_error > 0) begin
                host_dat_pull = 1'b0;
                tick();
                if (RX_VALID) n_valid++;
                if (RX_ERROR) n_error++;
                break;
            end
        end
        host_dat_pull = 1'b0;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        vec_count++; if ({PS2_CLK_OE, PS2_DATA_OE} !== 2'b00) begin err_count++; $display("FAIL rst_oe: got %b expected 00", {PS2_CLK_OE, PS2_DATA_OE}); end
        vec_count++; if ({TX_DONE, RX_VALID, RX_ERROR} !== 3'b000) begin err_count++; $display("FAIL rst_pulses: got %b expected 000", {TX_DONE, RX_VALID, RX_ERROR}); end
        RESETN = 1'b1;
        tick();
        vec_count++; if (TX_READY !== 1'b1) begin err_count++; $display("FAIL rst_tx_ready: got %b expected 1", TX_READY); end
        vec_count++; if (BUSY !== 1'b0) begin err_count++; $display("FAIL rst_busy: got %b expected 0", BUSY); end
        vec_count++; if (RX_DATA !== 8'h00) begin err_count++; $display("FAIL rst_rx_data: got %h expected 00", RX_DATA); end
        $display("test_reset done");
    endtask

    task automatic test_tx_basic();
        bit ok; bit done; logic [10:0] bits; int nedge, lat, t0;
        send_byte(8'hF4, ok);
        vec_count++; if (ok !== 1'b1) begin err_count++; $display("FAIL t1_accept: got %b expected 1", ok); end
        vec_count++; if ({TX_READY, BUSY} !== 2'b01) begin err_count++; $display("FAIL t1_pending: got ready/busy %b expected 01", {TX_READY, BUSY}); end
        tx_capture(600, bits, nedge, lat, t0, done);
        vec_count++; if (done !== 1'b1) begin err_count++; $display("FAIL t1_done: got %b expected 1", done); end
        vec_count++; if (nedge !== 11) begin err_count++; $display("FAIL t1_edges: got %0d expected 11", nedge); end
        vec_count++; if (bits !== 11'h5E8) begin err_count++; $display("FAIL t1_bits: got %h expected 5e8", bits); end
        vec_count++; if (lat !== 23 * HP) begin err_count++; $display("FAIL t1_latency: got %0d expected %0d", lat, 23 * HP); end
        tick();
        vec_count++; if ({TX_READY, TX_DONE, BUSY} !== 3'b100) begin err_count++; $display("FAIL t1_after: got ready/done/busy %b expected 100", {TX_READY, TX_DONE, BUSY}); end
        $display("test_tx_basic: byte f4 edges %0d bits %h latency %0d", nedge, bits, lat);
    endtask

    task automatic test_rx(input logic [7:0] b, input logic par, input logic stop,
                           input int exp_rises, input int exp_valid, input logic [7:0] exp_data);
        bit ok; int rises, nv, ne; logic ack_d, ack_h;
        host_send(b, par, stop, 100, ok, rises, ack_d, ack_h, nv, ne);
        vec_count++; if (ok !== 1'b1) begin err_count++; $display("FAIL rx_%h_clocks: got %b expected 1", b, ok); end
        vec_count++; if (rises !== exp_rises) begin err_count++; $display("FAIL rx_%h_ack_pulses: got %0d expected %0d", b, rises, exp_rises); end
        if (exp_rises == 1) begin
            vec_count++; if ({ack_d, ack_h} !== 2'b11) begin err_count++; $display("FAIL rx_%h_ack_data: got %b expected 11", b, {ack_d, ack_h}); end
        end
        vec_count++; if (nv !== exp_valid) begin err_count++; $display("FAIL rx_%h_valid: got %0d expected %0d", b, nv, exp_valid); end
        vec_count++; if (ne !== 1 - exp_valid) begin err_count++; $display("FAIL rx_%h_error: got %0d expected %0d", b, ne, 1 - exp_valid); end
        vec_count++; if (RX_DATA !== exp_data) begin err_count++; $display("FAIL rx_%h_data: got %h expected %h", b, RX_DATA, exp_data); end
        $display("test_rx: byte %h par %b stop %b pulses %0d valid %0d error %0d rx_data %h", b, par, stop, rises, nv, ne, RX_DATA);
    endtask

    task automatic test_tx_inhibit();
        bit ok; bit done; logic [10:0] bits; int nedge, lat, t0, bad; logic prev;
        send_byte(8'hAA, ok);
        nedge = 0;
        prev = ps2_clk_line;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (prev && !ps2_clk_line) nedge++;
            prev = ps2_clk_line;
            if (nedge == 5 && ps2_clk_line) break;
        end
        vec_count++; if (nedge !== 5) begin err_count++; $display("FAIL t4_reach_bit5: got %0d edges expected 5", nedge); end
        repeat (3) tick();
        host_clk_pull = 1'b1;
        repeat (6) tick();
        vec_count++; if (PS2_DATA_OE !== 1'b1) begin err_count++; $display("FAIL t4_drive_before_sample: got %b expected 1", PS2_DATA_OE); end
        tick();
        vec_count++; if ({PS2_CLK_OE, PS2_DATA_OE} !== 2'b00) begin err_count++; $display("FAIL t4_release: got %b expected 00", {PS2_CLK_OE, PS2_DATA_OE}); end
        bad = 0;
        repeat (30) begin
            tick();
            if (PS2_CLK_OE || PS2_DATA_OE || TX_DONE) bad++;
        end
        vec_count++; if (bad !== 0) begin err_count++; $display("FAIL t4_quiet: got %0d active cycles expected 0", bad); end
        vec_count++; if (BUSY !== 1'b1) begin err_count++; $display("FAIL t4_pending: got %b expected 1", BUSY); end
        host_clk_pull = 1'b0;
        tx_capture(600, bits, nedge, lat, t0, done);
        vec_count++; if (done !== 1'b1) begin err_count++; $display("FAIL t4_done: got %b expected 1", done); end
        vec_count++; if (bits !== 11'h754 || nedge !== 11) begin err_count++; $display("FAIL t4_resend: got %h/%0d expected 754/11", bits, nedge); end
        vec_count++; if (lat !== 23 * HP) begin err_count++; $display("FAIL t4_latency: got %0d expected %0d", lat, 23 * HP); end
        $display("test_tx_inhibit: resent bits %h edges %0d latency %0d", bits, nedge, lat);
    endtask

    task automatic test_rts_priority();
        bit ok; bit done; logic [10:0] bits; int nedge, lat, t0, rises, nv, ne; logic ack_d, ack_h;
        host_clk_pull = 1'b1;
        host_dat_pull = 1'b1;
        tick();
        tick();
        TX_DATA = 8'h5A;
        TX_VALID = 1'b1;
        tick();
        TX_VALID = 1'b0;
        vec_count++; if ({TX_READY, BUSY} !== 2'b01) begin err_count++; $display("FAIL t5_accept: got ready/busy %b expected 01", {TX_READY, BUSY}); end
        host_send(8'h3C, 1'b1, 1'b1, 97, ok, rises, ack_d, ack_h, nv, ne);
        vec_count++; if (ok !== 1'b1 || nv !== 1 || ne !== 0) begin err_count++; $display("FAIL t5_rx: got ok %b valid %0d error %0d expected 1 1 0", ok, nv, ne); end
        vec_count++; if (RX_DATA !== 8'h3C) begin err_count++; $display("FAIL t5_rx_data: got %h expected 3c", RX_DATA); end
        tx_capture(600, bits, nedge, lat, t0, done);
        vec_count++; if (done !== 1'b1 || bits !== 11'h6B4 || nedge !== 11) begin err_count++; $display("FAIL t5_tx: got done %b bits %h edges %0d expected 1 6b4 11", done, bits, nedge); end
        vec_count++; if (t0 < 22 || t0 > 30) begin err_count++; $display("FAIL t5_idle_gap: got %0d expected 22..30", t0); end
        $display("test_rts_priority: rx %h then tx bits %h after %0d cycles", RX_DATA, bits, t0);
    endtask

    task automatic test_reset_mid_tx();
        bit ok; int nedge, bad; logic prev;
        send_byte(8'h81, ok);
        nedge = 0;
        prev = ps2_clk_line;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (prev && !ps2_clk_line) nedge++;
            prev = ps2_clk_line;
            if (nedge == 3 && ps2_clk_line) break;
        end
        vec_count++; if (PS2_DATA_OE !== 1'b1 || nedge !== 3) begin err_count++; $display("FAIL t6_bit3: got oe %b edges %0d expected 1 3", PS2_DATA_OE, nedge); end
        #3;
        RESETN = 1'b0;
        #1;
        vec_count++; if ({PS2_CLK_OE, PS2_DATA_OE} !== 2'b00) begin err_count++; $display("FAIL t6_async_oe: got %b expected 00", {PS2_CLK_OE, PS2_DATA_OE}); end
        #3;
        RESETN = 1'b1;
        tick();
        vec_count++; if ({TX_READY, BUSY} !== 2'b10) begin err_count++; $display("FAIL t6_after: got ready/busy %b expected 10", {TX_READY, BUSY}); end
        bad = 0;
        repeat (300) begin
            tick();
            if (TX_DONE || PS2_DATA_OE || PS2_CLK_OE) bad++;
        end
        vec_count++; if (bad !== 0) begin err_count++; $display("FAIL t6_discard: got %0d active cycles expected 0", bad); end
        $display("test_reset_mid_tx: active cycles after reset %0d", bad);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tx_basic();
        test_rx(8'hFF, 1'b1, 1'b1, 1, 1, 8'hFF);
        test_rx(8'h00, 1'b0, 1'b1, 1, 0, 8'hFF);
        test_rx(8'h55, 1'b1, 1'b0, 0, 0, 8'hFF);
        test_tx_inhibit();
        test_rts_priority();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/ps2_device_xcvr.md
Name: ps2_device_xcvr

Overview:
- Device-side PS/2 transceiver: the device end of the PS/2 link that MouseTop drives as host.
- Generates PS2 clock; sends device-to-host frames; accepts host-to-device command frames and ACKs them; honours host inhibit.
- Used as a mouse emulator in the system bench and on a second board. Drives lines open-drain through OE outputs; the top level does the tristate.

Parameters:
HALF_PERIOD  2000  CLK cycles per PS2 clock half-phase (12.5 kHz at 50 MHz)
IDLE_MIN  2500  consecutive cycles with both lines high before a TX may start (50 us)
SYNC_STAGES  2  synchroniser depth on PS2_CLK_IN / PS2_DATA_IN

Ports:
CLK  in  1  system clock
RESETN  in  1  asynchronous active-low reset
TX_DATA  in  8  byte to send to host
TX_VALID  in  1  TX request; held until accepted
TX_READY  out  1  can accept a byte; transfer on TX_VALID & TX_READY
TX_DONE  out  1  1-cycle pulse when a frame completes
RX_DATA  out  8  last host byte received
RX_VALID  out  1  1-cycle pulse, good host byte
RX_ERROR  out  1  1-cycle pulse, parity or stop error
BUSY  out  1  state != IDLE or a byte is pending
PS2_CLK_IN  in  1  PS2 clock line level
PS2_CLK_OE  out  1  1 = pull clock low
PS2_DATA_IN  in  1  PS2 data line level
PS2_DATA_OE  out  1  1 = pull data low

Behaviour:
- Reset (async, RESETN=0): state IDLE; PS2_CLK_OE=0, PS2_DATA_OE=0; TX_DONE, RX_VALID, RX_ERROR=0; RX_DATA=0x00; pending cleared; idle counter cleared. TX_READY=1 from the first cycle after reset release.
- Inputs pass through SYNC_STAGES flops. All line decisions use the synced values sclk and sdat.
- TX_READY = (state==IDLE) & !pending.
  - On handshake, TX_DATA is latched and pending is set.
  - Pending clears only when TX_DONE fires.
- Idle counter: increments while sclk & sdat are both 1; saturates at IDLE_MIN; clears otherwise.
- States: IDLE, TX, INHIBIT, RX, ACK.
- IDLE:
  - If sclk=0, go to INHIBIT.
  - Else if pending and idle counter = IDLE_MIN, go to TX.
  - Host request-to-send has priority over pending TX.
- TX frame: 11 bits in order: start 0, D0..D7 (LSB first), odd parity, stop 1.
  - Per bit, high phase: PS2_DATA_OE = ~bit and PS2_CLK_OE = 0 for HALF_PERIOD cycles.
  - Per bit, low phase: PS2_CLK_OE = 1 for HALF_PERIOD cycles.
  - After bit 10's low phase: release both lines, wait HALF_PERIOD, pulse TX_DONE, go to IDLE.
  - Frame length is 23*HALF_PERIOD cycles from TX entry to TX_DONE.
- TX inhibit check: sclk is sampled on the last cycle of each high phase.
  - If it reads 0 before the 11th falling edge, release both lines and go to INHIBIT. Pending stays set; the whole frame is resent later.
  - No TX_DONE is issued for an aborted frame.
  - There is no check once the 11th falling edge has been driven.
- INHIBIT: both OE=0. Wait for sclk=1.
  - If sdat=0 at that point, go to RX.
  - Otherwise go to IDLE.
- RX (host-to-device): device generates 10 clock pulses, each a low phase then a high phase.
  - On the last cycle of the high phase of pulse k, sample sdat into bit k-1: D0..D7, parity, stop.
  - If sclk=0 at any of those sample points, abort to INHIBIT with no pulses.
- ACK:
  - If stop=0: no ACK, pulse RX_ERROR, go to IDLE.
  - Else: PS2_DATA_OE=1; drive clock low for HALF_PERIOD; release clock; hold for HALF_PERIOD; release data.
  - Then, if parity is odd-correct, update RX_DATA and pulse RX_VALID. If parity is bad, pulse RX_ERROR and leave RX_DATA unchanged.
  - Go to IDLE.
- All half-phase timing comes from one down-counter reloaded with HALF_PERIOD-1. A bit counter runs 0..10.

Test Plan:
1. HALF_PERIOD=10, IDLE_MIN=25, lines idle; TX_DATA=0xF4 accepted -> 11 falling edges; data at the falling edges is 0,0,0,1,0,1,1,1,1,0,1; TX_DONE 230 cycles after TX entry; TX_READY high the next cycle.
2. Host holds clock low 100 cycles, releases with data low, then clocks out 0xFF with parity 1 and stop 1 -> device drives data low across the 11th clock; RX_DATA=0xFF; one RX_VALID pulse.
3. Host sends 0x00 with parity 0 -> ACK still driven; RX_ERROR pulse; RX_VALID stays low; RX_DATA unchanged.
4. TX 0xAA; host pulls clock low during the bit-5 high phase -> both OE drop within 1 cycle of the sample point; no TX_DONE. After release plus 25 idle cycles, the full 0xAA frame is resent, then TX_DONE.
5. TX_VALID rises in the same cycle that sclk goes low with data low (RTS) -> RX completes first; the TX frame starts after IDLE_MIN; both bytes are correct.
6. RESETN=0 mid-TX at bit 3 -> both OE=0 asynchronously; after release TX_READY=1, BUSY=0, byte discarded, no TX_DONE.
